// File: rtl/multi_key_debounce_if.sv
// rtl/multi_key_debounce_if.sv - key inputs, repeat enable and debounced event outputs
interface multi_key_debounce_if #(
  parameter int CH = 4
);
  logic          rep_en;
  logic [CH-1:0] key_i;
  logic [CH-1:0] key_level;
  logic [CH-1:0] key_press;
  logic [CH-1:0] key_release;
  logic [CH-1:0] key_long;
  logic [CH-1:0] key_rep;

  // Key source side: drives raw keys and the repeat enable, consumes events.
  modport master (
    output rep_en,
    output key_i,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_long,
    input  key_rep
  );

  // Debouncer side.
  modport slave (
    input  rep_en,
    input  key_i,
    output key_level,
    output key_press,
    output key_release,
    output key_long,
    output key_rep
  );
endinterface

// File: rtl/multi_key_debounce.sv
// rtl/multi_key_debounce.sv - multi-channel key debouncer with long-press and auto-repeat
module multi_key_debounce #(
  parameter int CH         = 4,
  parameter int TICK_DIV   = 500000,
  parameter int DEPTH      = 8,
  parameter int LONG_TICKS = 100,
  parameter int REP_TICKS  = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multi_key_debounce_if.slave   bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam int RW = $clog2(REP_TICKS + 1);

  localparam logic [1:0] ST_RELEASED = 2'd0;
  localparam logic [1:0] ST_PRESSED  = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  // Shared sample-tick divider.
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick;

  // Two-stage synchroniser; idle level of the raw keys is 1.
  logic [CH-1:0]    sync1_q, sync2_q;

  // Per-channel debounce state.
  logic [DEPTH-1:0] shift_q   [CH];
  logic [DEPTH-1:0] shift_d   [CH];
  logic [1:0]       state_q   [CH];
  logic [1:0]       state_d   [CH];
  logic [HW-1:0]    hold_q    [CH];
  logic [HW-1:0]    hold_d    [CH];
  logic [RW-1:0]    rep_cnt_q [CH];
  logic [RW-1:0]    rep_cnt_d [CH];

  // Registered outputs.
  logic [CH-1:0]    level_q, level_d;
  logic [CH-1:0]    press_q, press_d;
  logic [CH-1:0]    release_q, release_d;
  logic [CH-1:0]    long_q, long_d;
  logic [CH-1:0]    rep_q, rep_d;

  // Tick is decoded from the counter so it lasts exactly one clk per period.
  always_comb begin
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Per-channel FSM: sample on tick, then decide press/release/long/repeat from the post-shift window.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      shift_d[c]   = shift_q[c];
      state_d[c]   = state_q[c];
      hold_d[c]    = hold_q[c];
      rep_cnt_d[c] = rep_cnt_q[c];
      level_d[c]   = level_q[c];
      press_d[c]   = 1'b0;
      release_d[c] = 1'b0;
      long_d[c]    = 1'b0;
      rep_d[c]     = 1'b0;

      if (tick) begin
        shift_d[c] = {shift_q[c][DEPTH-2:0], sync2_q[c]};
        case (state_q[c])
          ST_RELEASED: begin
            // Active-low keys: a window of all zeros is a stable press.
            if (shift_d[c] == '0) begin
              state_d[c]   = ST_PRESSED;
              level_d[c]   = 1'b1;
              press_d[c]   = 1'b1;
              hold_d[c]    = '0;
              rep_cnt_d[c] = '0;
            end
          end
          ST_PRESSED: begin
            // Release is checked first so it pre-empts a long press on the same tick.
            if (shift_d[c] == '1) begin
              state_d[c]   = ST_RELEASED;
              level_d[c]   = 1'b0;
              release_d[c] = 1'b1;
              hold_d[c]    = '0;
              rep_cnt_d[c] = '0;
            end else begin
              // Hold time keeps counting through bouncy windows; it never exceeds LONG_TICKS.
              hold_d[c] = hold_q[c] + 1'b1;
              if (hold_d[c] == HW'(LONG_TICKS)) begin
                state_d[c]   = ST_HELD;
                long_d[c]    = 1'b1;
                rep_cnt_d[c] = '0;
              end
            end
          end
          ST_HELD: begin
            if (shift_d[c] == '1) begin
              state_d[c]   = ST_RELEASED;
              level_d[c]   = 1'b0;
              release_d[c] = 1'b1;
              hold_d[c]    = '0;
              rep_cnt_d[c] = '0;
            end else if (bus.rep_en) begin
              // Repeat counter returns to zero on each pulse, so it never exceeds REP_TICKS.
              rep_cnt_d[c] = rep_cnt_q[c] + 1'b1;
              if (rep_cnt_d[c] == RW'(REP_TICKS)) begin
                rep_d[c]     = 1'b1;
                rep_cnt_d[c] = '0;
              end
            end else begin
              rep_cnt_d[c] = '0;
            end
          end
          default: begin
            // Unreachable encoding: fall back to a clean released state.
            state_d[c]   = ST_RELEASED;
            level_d[c]   = 1'b0;
            hold_d[c]    = '0;
            rep_cnt_d[c] = '0;
          end
        endcase
      end
    end
  end

  // Divider and synchroniser registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      sync1_q    <= '1;
      sync2_q    <= '1;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      sync1_q    <= bus.key_i;
      sync2_q    <= sync1_q;
    end
  end

  // Per-channel state and output registers; reset leaves every key released with no pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        shift_q[c]   <= '1;
        state_q[c]   <= ST_RELEASED;
        hold_q[c]    <= '0;
        rep_cnt_q[c] <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      rep_q     <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        shift_q[c]   <= shift_d[c];
        state_q[c]   <= state_d[c];
        hold_q[c]    <= hold_d[c];
        rep_cnt_q[c] <= rep_cnt_d[c];
      end
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      rep_q     <= rep_d;
    end
  end

  assign bus.key_level   = level_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = release_q;
  assign bus.key_long    = long_q;
  assign bus.key_rep     = rep_q;

endmodule

// File: tb/tb_multi_key_debounce.sv
// tb/tb_multi_key_debounce.sv - directed bench for multi_key_debounce
module tb_multi_key_debounce;
  localparam int CH         = 2;
  localparam int TICK_DIV   = 4;
  localparam int DEPTH      = 4;
  localparam int LONG_TICKS = 5;
  localparam int REP_TICKS  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  multi_key_debounce_if #(.CH(CH)) bus ();

  multi_key_debounce #(
    .CH(CH), .TICK_DIV(TICK_DIV), .DEPTH(DEPTH),
    .LONG_TICKS(LONG_TICKS), .REP_TICKS(REP_TICKS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] key;
    logic       rep_en;
    int         ticks;
    logic [1:0] lvl;
    logic [7:0] pr;
    logic [7:0] rl;
    logic [7:0] lg;
    logic [7:0] rp;
  } vec_t;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         pcnt [4][2];
  logic [1:0] prev_p [4];
  logic       both_press = 1'b0;
  logic       lvl_seen   = 1'b0;
  vec_t       tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 4; k++) begin
      pcnt[k][0] = 0;
      pcnt[k][1] = 0;
    end
  endtask

  function automatic logic [9:0] outs();
    return {bus.key_rep, bus.key_long, bus.key_release, bus.key_press, bus.key_level};
  endfunction

  // Event schedule of a ch0 press from reset release: press@16, long@36, rep@44/52/60, release@68.
  function automatic logic [9:0] exp_a(input int s);
    logic lv, pr, rl, lg, rp;
    lv = (s >= 16) && (s < 68);
    pr = (s == 16);
    lg = (s == 36);
    rp = (s == 44) || (s == 52) || (s == 60);
    rl = (s == 68);
    return {1'b0, rp, 1'b0, lg, 1'b0, rl, 1'b0, pr, 1'b0, lv};
  endfunction

  task automatic step();
    logic [1:0] p [4];
    @(posedge clk);
    @(negedge clk);
    cyc++;
    p[0] = bus.key_press;
    p[1] = bus.key_release;
    p[2] = bus.key_long;
    p[3] = bus.key_rep;
    for (int c = 0; c < 2; c++) begin
      logic [3:0] v;
      v = {p[3][c], p[2][c], p[1][c], p[0][c]};
      if (v != 4'd0) check($sformatf("onehot_ch%0d_cyc%0d", c, cyc), $countones(v), 1);
    end
    for (int k = 0; k < 4; k++) begin
      if (p[k] != 2'b00) check($sformatf("width_k%0d_cyc%0d", k, cyc), {30'd0, p[k] & prev_p[k]}, 0);
      for (int c = 0; c < 2; c++) pcnt[k][c] += int'(p[k][c]);
      prev_p[k] = p[k];
    end
    if (bus.key_press == 2'b11) both_press = 1'b1;
    if (bus.key_level != 2'b00) lvl_seen = 1'b1;
  endtask

  initial begin
    //            key    ren  tk lvl    press  rel    long   rep
    tbl[0]  = '{2'b00, 1'b0, 4, 2'b11, 8'h11, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{2'b00, 1'b0, 5, 2'b11, 8'h00, 8'h00, 8'h11, 8'h00};
    tbl[2]  = '{2'b00, 1'b0, 6, 2'b11, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[3]  = '{2'b01, 1'b0, 4, 2'b10, 8'h00, 8'h01, 8'h00, 8'h00};
    tbl[4]  = '{2'b01, 1'b1, 4, 2'b10, 8'h00, 8'h00, 8'h00, 8'h20};
    tbl[5]  = '{2'b11, 1'b1, 4, 2'b00, 8'h00, 8'h10, 8'h00, 8'h10};
    tbl[6]  = '{2'b10, 1'b1, 3, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[7]  = '{2'b11, 1'b1, 2, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[8]  = '{2'b10, 1'b1, 4, 2'b01, 8'h01, 8'h00, 8'h00, 8'h00};
    tbl[9]  = '{2'b10, 1'b1, 4, 2'b01, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[10] = '{2'b11, 1'b1, 2, 2'b01, 8'h00, 8'h00, 8'h01, 8'h00};
    tbl[11] = '{2'b10, 1'b1, 4, 2'b01, 8'h00, 8'h00, 8'h00, 8'h02};
    tbl[12] = '{2'b11, 1'b1, 4, 2'b00, 8'h00, 8'h01, 8'h00, 8'h02};

    for (int k = 0; k < 4; k++) prev_p[k] = 2'b00;
    clear_counts();

    // Reset state.
    bus.key_i  = 2'b11;
    bus.rep_en = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_level",   {30'd0, bus.key_level},   0);
    check("rst_press",   {30'd0, bus.key_press},   0);
    check("rst_release", {30'd0, bus.key_release}, 0);
    check("rst_long",    {30'd0, bus.key_long},    0);
    check("rst_rep",     {30'd0, bus.key_rep},     0);

    // Sequence A: ch0 press, long, repeats, release racing a repeat.
    bus.key_i  = 2'b10;
    bus.rep_en = 1'b1;
    rst_n      = 1'b1;
    cyc        = 0;
    for (int s = 1; s <= 72; s++) begin
      step();
      check($sformatf("seqA_cyc%0d", cyc), {22'd0, outs()}, {22'd0, exp_a(cyc)});
      if (cyc == 52) bus.key_i = 2'b11;
    end

    // Sequence B: ch0 bouncing every 3 clk never qualifies.
    clear_counts();
    lvl_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.key_i = {1'b1, ((i / 3) % 2 == 0) ? 1'b0 : 1'b1};
      step();
    end
    bus.key_i = 2'b11;
    repeat (24) step();
    check("bounce_pulses", pcnt[0][0] + pcnt[0][1] + pcnt[1][0] + pcnt[1][1] +
                           pcnt[2][0] + pcnt[2][1] + pcnt[3][0] + pcnt[3][1], 0);
    check("bounce_level_seen", {31'd0, lvl_seen}, 0);

    // Table: each record holds inputs for a whole number of ticks.
    both_press = 1'b0;
    for (int r = 0; r < 13; r++) begin
      logic [7:0] got [4];
      bus.key_i  = tbl[r].key;
      bus.rep_en = tbl[r].rep_en;
      clear_counts();
      repeat (tbl[r].ticks * TICK_DIV) step();
      for (int k = 0; k < 4; k++) got[k] = {4'(pcnt[k][1]), 4'(pcnt[k][0])};
      check($sformatf("tbl%0d_level", r),   {30'd0, bus.key_level}, {30'd0, tbl[r].lvl});
      check($sformatf("tbl%0d_press", r),   {24'd0, got[0]}, {24'd0, tbl[r].pr});
      check($sformatf("tbl%0d_release", r), {24'd0, got[1]}, {24'd0, tbl[r].rl});
      check($sformatf("tbl%0d_long", r),    {24'd0, got[2]}, {24'd0, tbl[r].lg});
      check($sformatf("tbl%0d_rep", r),     {24'd0, got[3]}, {24'd0, tbl[r].rp});
    end
    check("both_press_same_cycle", {31'd0, both_press}, 1);

    // Sequence C: reset while ch0 is in HELD, then re-debounce.
    bus.key_i  = 2'b10;
    bus.rep_en = 1'b1;
    clear_counts();
    repeat (40) step();
    check("seqC_pre_level", {30'd0, bus.key_level}, 1);
    check("seqC_pre_press", pcnt[0][0], 1);
    check("seqC_pre_long",  pcnt[2][0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("seqC_async_outs", {22'd0, outs()}, 0);
    for (int k = 0; k < 4; k++) prev_p[k] = 2'b00;
    clear_counts();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    for (int s = 1; s <= 20; s++) begin
      step();
      check($sformatf("seqC_cyc%0d", cyc), {22'd0, outs()}, {22'd0, exp_a(cyc)});
    end
    check("seqC_no_release", pcnt[1][0] + pcnt[1][1], 0);
    check("seqC_press_count", pcnt[0][0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multi_key_debounce.md
MULTI_KEY_DEBOUNCE -- requirements
Module: multi_key_debounce

Interface
REQ-001 Parameter CH, default 4, number of independent key channels (1..16).
REQ-002 Parameter TICK_DIV, default 500000, sample-tick period in clk cycles (>=2); 10 ms at 50 MHz.
REQ-003 Parameter DEPTH, default 8, consecutive equal samples required for a state change (2..16).
REQ-004 Parameter LONG_TICKS, default 100, ticks of continuous press before the long-press pulse (>=1).
REQ-005 Parameter REP_TICKS, default 20, ticks between auto-repeat pulses after a long press (>=1).
REQ-006 clk  input  1  system clock; all logic on posedge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 rep_en  input  1  auto-repeat enable, sampled each tick.
REQ-009 key_i  input  CH  raw key inputs, active-low (idle 1), asynchronous to clk.
REQ-010 key_level  output  CH  debounced state per channel, 1 = pressed.
REQ-011 key_press  output  CH  one-clk pulse on a debounced press.
REQ-012 key_release  output  CH  one-clk pulse on a debounced release.
REQ-013 key_long  output  CH  one-clk pulse when a press reaches LONG_TICKS.
REQ-014 key_rep  output  CH  one-clk auto-repeat pulse.

Function
REQ-015 Each key_i bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-016 A shared tick counter SHALL count 0..TICK_DIV-1 and wrap; tick SHALL be high for exactly one clk when the count equals TICK_DIV-1.
REQ-017 Per channel, on each tick, a DEPTH-bit shift register SHALL shift in the synchronised sample; it SHALL hold between ticks.
REQ-018 Per-channel FSM states: RELEASED, PRESSED, HELD.
REQ-019 RELEASED->PRESSED when the post-shift register is all zeros: key_level <= 1 and key_press pulses, both on the tick edge.
REQ-020 PRESSED or HELD->RELEASED when the post-shift register is all ones: key_level <= 0 and key_release pulses on the tick edge; hold and repeat counters cleared.
REQ-021 In PRESSED, a hold counter SHALL increment once per tick; on the tick it reaches LONG_TICKS: key_long pulses, state->HELD, repeat counter cleared.
REQ-022 In HELD with rep_en=1, the repeat counter SHALL increment per tick; on reaching REP_TICKS, key_rep pulses and the counter returns to 0; with rep_en=0 the counter SHALL stay 0 and no key_rep SHALL fire.
REQ-023 If release qualifies on the same tick as long or repeat would fire, release SHALL win; key_long/key_rep SHALL NOT pulse.
REQ-024 Mixed shift patterns (not all 0 / all 1) SHALL leave state and counters unchanged except hold/repeat counting per REQ-021/022.
REQ-025 At most one of key_press, key_release, key_long, key_rep SHALL be high per channel per cycle; all pulses SHALL be exactly one clk wide.
REQ-026 Counter widths SHALL be sized by $clog2 from the parameters; no counter SHALL wrap silently.
REQ-027 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-028 Debounce latency from a stable synchronised level change to key_press/key_release SHALL be DEPTH ticks (plus tick phase and 2 clk of synchroniser).

Reset
REQ-029 On rst_n low, asynchronously: tick counter 0, synchronisers and shift registers all ones, FSMs RELEASED, hold/repeat counters 0, all outputs 0.
REQ-030 Reset asserted mid-press SHALL produce no key_release; after deassertion a held key SHALL be re-debounced and report key_press.

Verification (TICK_DIV=4, DEPTH=4, LONG_TICKS=5, REP_TICKS=2, CH=2)
REQ-031 key_i[0] 1->0, held -> key_press[0] one clk after the 4th tick sampling 0; key_level[0]=1.
REQ-032 key_i[0] toggles every 3 clk for 40 clk -> no pulses on any output, key_level=0.
REQ-033 Press held, rep_en=1 -> key_long 5 ticks after key_press, then key_rep every 2 ticks; release -> one key_release, key_level=0.
REQ-034 Same with rep_en=0 -> key_long once, no key_rep.
REQ-035 Both channels pressed on the same clk -> key_press=2'b11 in the same cycle.
REQ-036 rst_n pulsed low while key held in HELD -> outputs 0 immediately, no key_release; key_press re-fires DEPTH ticks after deassertion.
